// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   uart_tx_state_t   : transmitter FSM states (IDLE/START/DATA/STOP)
//   UART_CLKS_PER_BIT : default system clocks per serial bit (50 MHz / 9600)
//   UART_DATA_BITS    : data bits per frame (8N1)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 5208;
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-time counter shared by the UART transmitter and receiver. Counts
// 0..CLKS_PER_BIT-1 and wraps; tick is high in the last clock of each bit.
//   clk   in  system clock
//   rst_n in  asynchronous reset, active low
//   clear in  hold the counter at zero (used to restart timing on state entry)
//   tick  out high when the counter is at CLKS_PER_BIT-1
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule : uart_baud_tick

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// 8N1 UART transmitter, LSB first. A byte written while tx_ready is high is
// framed as START, 8 DATA bits, STOP, each bit CLKS_PER_BIT clocks long.
//   clk      in   system clock
//   rst_n    in   asynchronous reset, active low (aborts a frame, line -> 1)
//   tx_start in   one-cycle write strobe
//   tx_data  in   byte to send, sampled when tx_start && tx_ready
//   tx_ready out  a write this cycle will be accepted
//   tx_busy  out  a frame is on the line
//   tx_done  out  one-cycle pulse in the last clock of the stop bit
//   uart_tx  out  registered serial line, idles high
// Build option: define UART_TX_HOLD_EN to add a one-byte holding register so
// a byte written mid-frame follows the current frame with no idle gap.
// -----------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t state, state_next;
  logic [7:0]     shift, shift_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic           uart_tx_next;
  logic           bit_tick;
  logic           accept;

  // The timer is held at zero in IDLE, so START always begins a full bit.
  // Every later state change happens on a tick, where the counter wraps to
  // zero by itself, which gives a fresh bit time on each state entry.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state == IDLE),
    .tick (bit_tick)
  );

`ifdef UART_TX_HOLD_EN
  logic       hold_valid, hold_valid_next;
  logic [7:0] hold_data, hold_data_next;

  assign tx_ready = !hold_valid;
`else
  assign tx_ready = (state == IDLE);
`endif

  assign accept  = tx_start && tx_ready;
  assign tx_busy = (state != IDLE);
  assign tx_done = (state == STOP) && bit_tick;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
`ifdef UART_TX_HOLD_EN
    hold_valid_next = hold_valid;
    hold_data_next  = hold_data;
`endif

    unique case (state)
      IDLE: begin
        if (accept) begin
          shift_next   = tx_data;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_tick) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_next = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_next = IDLE;
`ifdef UART_TX_HOLD_EN
          // Drain the held byte straight into the next frame; with the hold
          // empty, a write landing in this cycle is started the same way.
          if (hold_valid) begin
            shift_next      = hold_data;
            hold_valid_next = 1'b0;
            bit_idx_next    = '0;
            state_next      = START;
          end else if (accept) begin
            shift_next   = tx_data;
            bit_idx_next = '0;
            state_next   = START;
          end
`endif
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef UART_TX_HOLD_EN
    // Mid-frame writes park in the hold register; the drain cycle is
    // handled above.
    if (accept && (state != IDLE) && !((state == STOP) && bit_tick)) begin
      hold_valid_next = 1'b1;
      hold_data_next  = tx_data;
    end
`endif

    // The line is registered, so it is driven from the next-cycle view.
    unique case (state_next)
      START:   uart_tx_next = 1'b0;
      DATA:    uart_tx_next = shift_next[0];
      default: uart_tx_next = 1'b1;
    endcase
  end

  // NOTE: the datapath registers are reset as well as the control state, so
  // a frame aborted by reset leaves no stale byte behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      uart_tx <= uart_tx_next;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      hold_valid <= hold_valid_next;
      hold_data  <= hold_data_next;
    end
  end
`endif

endmodule : uart_tx_engine

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Self-checking bench for uart_tx_engine with CLKS_PER_BIT = 4. A frame-level
// model (frame start cycle + byte, optional held byte) predicts the outputs on
// every cycle; literal expectations on logged line samples pin the model.
// Builds with or without UART_TX_HOLD_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;
  localparam int LOG_N = 2048;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_tx;

  uart_tx_engine #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  // Cycle t spans posedge t to posedge t+1; inputs change 1 time unit after
  // the posedge and outputs are sampled on the negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model ---
  logic tx_log[LOG_N];
  logic done_log[LOG_N];
  logic ready_log[LOG_N];
  logic busy_log[LOG_N];
  int   dut_done_count = 0;

  bit         m_active     = 1'b0;
  int         m_start      = 0;
  logic [7:0] m_byte       = 8'h00;
  bit         m_hold_valid = 1'b0;
  logic [7:0] m_hold_byte  = 8'h00;

  // Line level k cycles into a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int i;
    i = k / C;
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  always @(negedge clk) begin
    logic e_tx, e_busy, e_done, e_ready, acc;
    int   k, t;
    t = cyc;
    if (!rst_n) begin
      m_active     = 1'b0;
      m_hold_valid = 1'b0;
    end
    k      = t - m_start;
    e_busy = m_active;
    e_tx   = m_active ? frame_bit(m_byte, k) : 1'b1;
    e_done = m_active && (k == FRAME - 1);
`ifdef UART_TX_HOLD_EN
    e_ready = !m_hold_valid;
`else
    e_ready = !m_active;
`endif
    check("model uart_tx",  uart_tx,  e_tx);
    check("model tx_busy",  tx_busy,  e_busy);
    check("model tx_done",  tx_done,  e_done);
    check("model tx_ready", tx_ready, e_ready);

    if (t < LOG_N) begin
      tx_log[t]    = uart_tx;
      done_log[t]  = tx_done;
      ready_log[t] = tx_ready;
      busy_log[t]  = tx_busy;
    end
    if (tx_done === 1'b1) dut_done_count++;

    if (rst_n) begin
      acc = tx_start && e_ready;
      if (e_done) begin
        if (m_hold_valid) begin
          m_start      = t + 1;
          m_byte       = m_hold_byte;
          m_hold_valid = 1'b0;
        end else if (acc) begin
          m_start = t + 1;
          m_byte  = tx_data;
        end else begin
          m_active = 1'b0;
        end
      end else if (acc) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_start  = t + 1;
          m_byte   = tx_data;
        end else begin
          m_hold_valid = 1'b1;
          m_hold_byte  = tx_data;
        end
      end
    end
  end

  // ------------------------------------------------------------- helpers ---
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold tx_start high for exactly cycle t.
  task automatic write_at(input logic [7:0] d, input int t);
    wait_until(t);
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  // Byte carried by a frame whose start bit begins at cycle f (mid-bit samples).
  function automatic logic [7:0] line_byte(input int f);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = tx_log[f + C * (i + 1) + 2];
    return b;
  endfunction

  function automatic int count_ones(ref logic arr[LOG_N], input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) if (arr[i] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

  // ------------------------------------------------------------ stimulus ---
  initial begin
    int         s;
    int         d0;
    logic [9:0] seq55;
    seq55 = 10'b1010101010;  // index i = line level in bit slot i

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset.
    wait_until(cyc + 50);
    check("idle tx_ready", tx_ready, 1'b1);
    check("idle uart_tx", uart_tx, 1'b1);
    check("idle tx_busy", tx_busy, 1'b0);
    check("idle no tx_done", dut_done_count, 0);

    // Single frame 0x55.
    s = cyc + 2;
    write_at(8'h55, s);
    wait_until(s + 45);
    check("55 line idle in strobe cycle", tx_log[s], 1'b1);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < C; j++)
        check($sformatf("55 bit %0d clk %0d", i, j), tx_log[s + 1 + C * i + j], seq55[i]);
    check("55 busy rises", busy_log[s + 1], 1'b1);
    check("55 done before", done_log[s + 39], 1'b0);
    check("55 done at 40", done_log[s + 40], 1'b1);
    check("55 done after", done_log[s + 41], 1'b0);
    check("55 idle after frame busy", busy_log[s + 41], 1'b0);
    check("55 ready after frame", ready_log[s + 41], 1'b1);
`ifndef UART_TX_HOLD_EN
    check("55 ready falls", ready_log[s + 1], 1'b0);
    check("55 ready low at done", ready_log[s + 40], 1'b0);

    // Second write mid-frame is dropped without hold.
    s = cyc + 2;
    write_at(8'hA3, s);
    write_at(8'h7E, s + 10);
    wait_until(s + 60);
    check("A3 byte on line", line_byte(s + 1), 8'hA3);
    check("A3 single done", count_ones(done_log, s, s + 59), 1);
    check("A3 line idle after", count_ones(tx_log, s + 41, s + 59), 19);

    // Write in the tx_done cycle is dropped; one cycle later is accepted.
    s = cyc + 2;
    write_at(8'h3C, s);
    write_at(8'h99, s + 40);
    write_at(8'hC5, s + 41);
    wait_until(s + 90);
    check("drain done", done_log[s + 40], 1'b1);
    check("drain dropped line", tx_log[s + 41], 1'b1);
    check("drain start bit", tx_log[s + 42], 1'b0);
    check("drain 3C byte", line_byte(s + 1), 8'h3C);
    check("drain C5 byte", line_byte(s + 42), 8'hC5);
    check("drain C5 done", done_log[s + 81], 1'b1);
    check("drain done count", count_ones(done_log, s, s + 89), 2);
`else
    check("55 ready stays high", ready_log[s + 1], 1'b1);

    // Back-to-back frames through the hold register.
    s = cyc + 2;
    write_at(8'h01, s);
    write_at(8'hFF, s + 10);
    wait_until(s + 90);
    check("hold ready at write", ready_log[s + 10], 1'b1);
    check("hold ready low", ready_log[s + 11], 1'b0);
    check("hold ready low at done", ready_log[s + 40], 1'b0);
    check("hold ready back", ready_log[s + 41], 1'b1);
    check("hold first done", done_log[s + 40], 1'b1);
    check("hold second done", done_log[s + 80], 1'b1);
    check("hold done count", count_ones(done_log, s, s + 89), 2);
    check("hold busy span", count_ones(busy_log, s + 1, s + 80), 80);
    check("hold busy ends", busy_log[s + 81], 1'b0);
    check("hold no gap", tx_log[s + 41], 1'b0);
    check("hold first byte", line_byte(s + 1), 8'h01);
    check("hold second byte", line_byte(s + 41), 8'hFF);
`endif

    // Reset during data bit 3 of 0x00.
    s = cyc + 2;
    write_at(8'h00, s);
    wait_until(s + 18);
    check("rst line low before", tx_log[s + 17], 1'b0);
    check("rst busy before", busy_log[s + 17], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst line high at once", uart_tx, 1'b1);
    check("rst busy clears", tx_busy, 1'b0);
    wait_until(cyc + 2);
    rst_n = 1'b1;
    d0 = dut_done_count;
    wait_until(cyc + 50);
    check("rst no done", dut_done_count, d0);
    check("rst ready", tx_ready, 1'b1);
    check("rst line idle", uart_tx, 1'b1);

    wait_until(cyc + 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_engine

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmitter for the CPU's UART link: accepts a byte from the memory stage's UART data-register store and shifts it out on `uart_tx` as an 8N1 frame, LSB first. It is the transmit counterpart of the UART receive path that feeds the decode stage, and it shares the same clock, reset and baud rate. Status outputs let the CPU poll readiness and raise a completion interrupt.

## Interface
- `CLKS_PER_BIT`, default 5208; system clocks per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active low.
- `tx_start`  in  1  write strobe from the MEM-stage store to the UART TX data address; valid for one cycle.
- `tx_data`  in  8  byte to send; sampled only when `tx_start && tx_ready`.
- `tx_ready`  out  1  high when a write will be accepted.
- `tx_busy`  out  1  high while a frame is on the line (START, DATA or STOP state).
- `tx_done`  out  1  one-cycle pulse in the last clock of a stop bit.
- `uart_tx`  out  1  serial line; registered output; idles high.

## Operation
- The FSM has four states: IDLE, START, DATA and STOP.
- IDLE: `uart_tx`=1. Accepted write → latch `tx_data` into the shift register, reset the bit counter, go to START.
- START: `uart_tx`=0 for one bit time, then DATA with bit index 0.
- DATA: `uart_tx`=shift[0] for each bit time. After each bit, shift right and increment the index. After index 7, go to STOP.
- STOP: `uart_tx`=1 for one bit time. On the final clock, `tx_done`=1. Then go to IDLE, or go to START if a held byte is pending (see Configuration).
- Bit timer: a counter runs 0..CLKS_PER_BIT-1. The bit-end tick fires at CLKS_PER_BIT-1, and the counter is cleared on each state entry.
- `tx_ready` without the hold feature: state==IDLE.
- Writes made while `tx_ready`=0 are dropped silently. They have no effect on the frame in progress or on the outputs.
- A write in the same cycle as `tx_done`: `tx_ready` is still low without hold, so the write is dropped. Software must poll `tx_ready`.
- Reset values: state IDLE, `uart_tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, shift register 0, hold register empty.
- Reset asserted mid-frame aborts the frame immediately. The line goes high asynchronously, with no partial stop bit.

## Timing
- Accepted write at cycle N → `uart_tx` falls at N+1 and `tx_busy` rises at N+1. `tx_ready` falls at N+1 when there is no hold feature.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame is 10×CLKS_PER_BIT cycles.
- `tx_done` is high in cycle N+10×CLKS_PER_BIT. IDLE and `tx_ready`=1 follow in the next cycle.
- Minimum write-to-write spacing without hold: 10×CLKS_PER_BIT+1 cycles.

## Configuration
- `UART_TX_HOLD_EN` defined: a one-byte holding register is included.
  - `tx_ready` = !hold_valid.
  - A write during IDLE loads the shifter directly.
  - A write while busy loads the hold register.
  - At the end of STOP with hold_valid set: move hold→shift, clear hold_valid, and enter START the next cycle. This gives back-to-back frames with no idle gap.
  - A write in the drain cycle is accepted only if hold was empty at that cycle.
- `UART_TX_HOLD_EN` undefined: there is no hold register and `tx_ready`=IDLE. All other behaviour is identical.

## Structure
- Shared package `uart_pkg`:
  - the `uart_tx_state_t` enum (IDLE/START/DATA/STOP);
  - the `UART_CLKS_PER_BIT` default constant (5208), also used by the receiver;
  - the `UART_DATA_BITS`=8 constant.
- One sub-module, `uart_baud_tick`: a bit-time counter with a clear input and a tick output. It is parameterised by CLKS_PER_BIT so the receiver can reuse it.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset, then idle for 50 cycles → `uart_tx`=1, `tx_ready`=1, `tx_busy`=0, no `tx_done`.
- Write 0x55 → line shows 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles. The start bit begins 1 cycle after the strobe. `tx_done` pulses at cycle 40 after the strobe.
- Write 0xA3, then write 0x7E 10 cycles later with hold disabled → only 0xA3 appears on the line, and 0x7E is dropped.
- With `UART_TX_HOLD_EN`, write 0x01 then 0xFF during the first frame → two contiguous frames of 80 cycles total. `tx_ready` is low only while the hold register is full. Two `tx_done` pulses occur, 40 cycles apart.
- Assert `rst_n`=0 during the DATA bit 3 of 0x00 → `uart_tx`=1 immediately. After release, `tx_ready`=1 and no `tx_done` pulse occurs.
- Write at exactly the `tx_done` cycle with hold disabled → the write is dropped. A write one cycle later is accepted and its start bit appears on the next cycle.
